// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
//   sched_state_t : scheduler states
//   SEL_*         : baud select codes understood by the UART baud generator
//   idx_w()       : index width helper (never narrower than one bit)
package uart_sched_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CFG       = 3'd1,
        LOAD      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } sched_state_t;

    localparam logic [SEL_W-1:0] SEL_9600  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_19200 = 3'b010;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N.
//   req      : request vector
//   ptr      : highest-priority index for this pick
//   onehot_c : one-hot winner (zero when nothing requests)
//   idx_c    : winner index
//   valid_c  : at least one request asserted
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot_c,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IW:0] cand;

    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        valid_c  = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!valid_c && req[cand[IW-1:0]]) begin
                valid_c                 = 1'b1;
                idx_c                   = cand[IW-1:0];
                onehot_c[cand[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ producers.
// Owns the transmitter controls (baud enable/select, start, data byte),
// sequences one byte per frame and reports grants, completion and errors.
//   clk, rst           : clock, asynchronous active-low reset
//   req, req_data      : per-producer level request and byte
//   gnt                : one-cycle one-hot pulse when a byte is accepted
//   cfg_sel, cfg_we    : baud select write (applied from IDLE)
//   err_clr            : clears sticky error flags
//   ena_baud, sel      : baud generator enable and select
//   ena_Tx, data_in_Tx : transmitter start and byte
//   busy_Tx, err_Tx    : transmitter status
//   done               : one-cycle pulse at end of each frame
//   err_to, err_frame  : sticky start-timeout / frame-error flags
//   idle               : scheduler in IDLE
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned      N_REQ    = 4,
    parameter int unsigned      START_TO = 20000,
    parameter logic [SEL_W-1:0] RST_SEL  = SEL_19200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]              gnt,
    input  logic [SEL_W-1:0]              cfg_sel,
    input  logic                          cfg_we,
    input  logic                          err_clr,
    output logic                          ena_baud,
    output logic [SEL_W-1:0]              sel,
    output logic                          ena_Tx,
    output logic [DATA_W-1:0]             data_in_Tx,
    input  logic                          busy_Tx,
    input  logic                          err_Tx,
    output logic                          done,
    output logic                          err_to,
    output logic                          err_frame,
    output logic                          idle
);

    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned TW = idx_w(START_TO);

    sched_state_t      state, state_nxt;
    logic [IW-1:0]     ptr, ptr_nxt;
    logic [IW-1:0]     win, win_nxt;
    logic [N_REQ-1:0]  win_oh, win_oh_nxt;
    logic [TW-1:0]     cnt, cnt_nxt;
    logic              busy_q;
    logic              pend, pend_nxt;
    logic [SEL_W-1:0]  pend_sel, pend_sel_nxt;

    logic [N_REQ-1:0]  gnt_nxt;
    logic              ena_baud_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic              ena_tx_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              done_nxt;
    logic              err_to_nxt;
    logic              err_frame_nxt;
    logic              idle_nxt;
    logic              set_to;
    logic              set_frame;

    logic [N_REQ-1:0]  arb_onehot_c;
    logic [IW-1:0]     arb_idx_c;
    logic              arb_valid_c;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req      (req),
        .ptr      (ptr),
        .onehot_c (arb_onehot_c),
        .idx_c    (arb_idx_c),
        .valid_c  (arb_valid_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            win_oh     <= '0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            pend       <= 1'b0;
            pend_sel   <= RST_SEL;
            gnt        <= '0;
            ena_baud   <= 1'b0;
            sel        <= RST_SEL;
            ena_Tx     <= 1'b0;
            data_in_Tx <= '0;
            done       <= 1'b0;
            err_to     <= 1'b0;
            err_frame  <= 1'b0;
            idle       <= 1'b1;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            win        <= win_nxt;
            win_oh     <= win_oh_nxt;
            cnt        <= cnt_nxt;
            busy_q     <= busy_Tx;
            pend       <= pend_nxt;
            pend_sel   <= pend_sel_nxt;
            gnt        <= gnt_nxt;
            ena_baud   <= ena_baud_nxt;
            sel        <= sel_nxt;
            ena_Tx     <= ena_tx_nxt;
            data_in_Tx <= data_nxt;
            done       <= done_nxt;
            err_to     <= err_to_nxt;
            err_frame  <= err_frame_nxt;
            idle       <= idle_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        win_nxt      = win;
        win_oh_nxt   = win_oh;
        cnt_nxt      = cnt;
        pend_nxt     = pend;
        pend_sel_nxt = pend_sel;
        gnt_nxt      = '0;
        ena_baud_nxt = 1'b1;
        sel_nxt      = sel;
        ena_tx_nxt   = ena_Tx;
        data_nxt     = data_in_Tx;
        done_nxt     = 1'b0;
        set_to       = 1'b0;
        set_frame    = 1'b0;

        case (state)
            IDLE: begin
                // Baud is gated off while the new select takes effect.
                if (pend) begin
                    state_nxt    = CFG;
                    ena_baud_nxt = 1'b0;
                    sel_nxt      = pend_sel;
                    pend_nxt     = 1'b0;
                end else if (|req) begin
                    state_nxt = LOAD;
                end
            end
            CFG: begin
                state_nxt = IDLE;
            end
            LOAD: begin
                // Requests withdrawn since IDLE leave nothing to send.
                if (arb_valid_c) begin
                    win_nxt    = arb_idx_c;
                    win_oh_nxt = arb_onehot_c;
                    data_nxt   = req_data[arb_idx_c];
                    ena_tx_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = WAIT_BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_BUSY: begin
                set_frame = err_Tx;
                if (busy_Tx) begin
                    gnt_nxt    = win_oh;
                    ena_tx_nxt = 1'b0;
                    ptr_nxt    = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
                    state_nxt  = WAIT_DONE;
                end else if (cnt == TW'(START_TO - 1)) begin
                    ena_tx_nxt = 1'b0;
                    set_to     = 1'b1;
                    state_nxt  = IDLE;
                end else if (cnt != {TW{1'b1}}) begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
            WAIT_DONE: begin
                set_frame = err_Tx;
                if (busy_q && !busy_Tx) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A write arriving on the CFG entry cycle stays pending for the next pass.
        if (cfg_we) begin
            pend_nxt     = 1'b1;
            pend_sel_nxt = cfg_sel;
        end

        err_to_nxt    = set_to    | (err_to    & ~err_clr);
        err_frame_nxt = set_frame | (err_frame & ~err_clr);
        idle_nxt      = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed stimulus with a UART/producer
// responder, a behavioural expectation model checked every cycle, and
// literal checks on key scenarios.
module tb_uart_tx_scheduler;

    localparam int N_REQ    = 4;
    localparam int START_TO = 20000;
    localparam int DLY      = 3;
    localparam int FRAME    = 5;

    localparam int P_IDLE = 0;
    localparam int P_CFG  = 1;
    localparam int P_LOAD = 2;
    localparam int P_WB   = 3;
    localparam int P_WD   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0][7:0] req_data;
    logic [N_REQ-1:0]      gnt;
    logic [2:0]            cfg_sel;
    logic                  cfg_we;
    logic                  err_clr;
    logic                  ena_baud;
    logic [2:0]            sel;
    logic                  ena_Tx;
    logic [7:0]            data_in_Tx;
    logic                  busy_Tx;
    logic                  err_Tx;
    logic                  done;
    logic                  err_to;
    logic                  err_frame;
    logic                  idle;

    uart_tx_scheduler #(
        .N_REQ    (N_REQ),
        .START_TO (START_TO),
        .RST_SEL  (3'b010)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .cfg_sel    (cfg_sel),
        .cfg_we     (cfg_we),
        .err_clr    (err_clr),
        .ena_baud   (ena_baud),
        .sel        (sel),
        .ena_Tx     (ena_Tx),
        .data_in_Tx (data_in_Tx),
        .busy_Tx    (busy_Tx),
        .err_Tx     (err_Tx),
        .done       (done),
        .err_to     (err_to),
        .err_frame  (err_frame),
        .idle       (idle)
    );

    // ---------------- expectation model ----------------
    int               m_ph;
    int               m_ptr;
    int               m_win;
    int               m_wcnt;
    logic             m_pend;
    logic [2:0]       m_psel;
    logic [N_REQ-1:0] e_gnt;
    logic             e_baud;
    logic [2:0]       e_sel;
    logic             e_ena;
    logic [7:0]       e_data;
    logic             e_done;
    logic             e_to;
    logic             e_fr;
    logic             set_to;
    logic             set_fr;
    logic             found;
    int               c;
    int               w;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph   <= P_IDLE;
            m_ptr  <= 0;
            m_win  <= 0;
            m_wcnt <= 0;
            m_pend <= 1'b0;
            m_psel <= 3'b010;
            e_gnt  <= '0;
            e_baud <= 1'b0;
            e_sel  <= 3'b010;
            e_ena  <= 1'b0;
            e_data <= 8'h00;
            e_done <= 1'b0;
            e_to   <= 1'b0;
            e_fr   <= 1'b0;
        end else begin
            set_to = 1'b0;
            set_fr = 1'b0;
            e_gnt  <= '0;
            e_done <= 1'b0;
            e_baud <= 1'b1;
            case (m_ph)
                P_IDLE: begin
                    if (m_pend) begin
                        m_ph   <= P_CFG;
                        e_baud <= 1'b0;
                        e_sel  <= m_psel;
                        m_pend <= 1'b0;
                    end else if (req != '0) begin
                        m_ph <= P_LOAD;
                    end
                end
                P_CFG: m_ph <= P_IDLE;
                P_LOAD: begin
                    found = 1'b0;
                    w = 0;
                    for (int k = 0; k < N_REQ; k++) begin
                        c = (m_ptr + k) % N_REQ;
                        if (!found && req[c]) begin
                            found = 1'b1;
                            w = c;
                        end
                    end
                    if (found) begin
                        m_win  <= w;
                        e_data <= req_data[w];
                        e_ena  <= 1'b1;
                        m_wcnt <= 0;
                        m_ph   <= P_WB;
                    end else begin
                        m_ph <= P_IDLE;
                    end
                end
                P_WB: begin
                    set_fr = err_Tx;
                    if (busy_Tx) begin
                        e_gnt <= 4'(1) << m_win;
                        e_ena <= 1'b0;
                        m_ptr <= (m_win + 1) % N_REQ;
                        m_ph  <= P_WD;
                    end else if (m_wcnt == START_TO - 1) begin
                        e_ena  <= 1'b0;
                        set_to = 1'b1;
                        m_ph   <= P_IDLE;
                    end else begin
                        m_wcnt <= m_wcnt + 1;
                    end
                end
                P_WD: begin
                    set_fr = err_Tx;
                    // Busy is known high on entry, so the first low sample is the fall.
                    if (!busy_Tx) begin
                        e_done <= 1'b1;
                        m_ph   <= P_IDLE;
                    end
                end
                default: m_ph <= P_IDLE;
            endcase
            if (cfg_we) begin
                m_pend <= 1'b1;
                m_psel <= cfg_sel;
            end
            e_to <= set_to ? 1'b1 : (err_clr ? 1'b0 : e_to);
            e_fr <= set_fr ? 1'b1 : (err_clr ? 1'b0 : e_fr);
        end
    end

    // ---------------- checking ----------------
    int total  = 0;
    int bad    = 0;
    int nprint = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (nprint < 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
                nprint++;
            end
        end
    endtask

    task automatic compare_all();
        chk("cyc_gnt",       32'(gnt),        32'(e_gnt));
        chk("cyc_ena_baud",  32'(ena_baud),   32'(e_baud));
        chk("cyc_sel",       32'(sel),        32'(e_sel));
        chk("cyc_ena_Tx",    32'(ena_Tx),     32'(e_ena));
        chk("cyc_data",      32'(data_in_Tx), 32'(e_data));
        chk("cyc_done",      32'(done),       32'(e_done));
        chk("cyc_err_to",    32'(err_to),     32'(e_to));
        chk("cyc_err_frame", 32'(err_frame),  32'(e_fr));
        chk("cyc_idle",      32'(idle),       32'(m_ph == P_IDLE));
    endtask

    // ---------------- UART and producer responders ----------------
    logic uart_on;
    logic keep_req;
    int   u_ph;
    int   u_cnt;
    int   gcount;
    int   dcount;
    logic [N_REQ-1:0] last_gnt;
    int   gq[$];

    task automatic uart_step();
        if (!rst) begin
            u_ph    = 0;
            busy_Tx = 1'b0;
        end else begin
            case (u_ph)
                0: if (uart_on && ena_Tx) begin
                    u_cnt = DLY - 1;
                    u_ph  = 1;
                end
                1: if (u_cnt == 0) begin
                    busy_Tx = 1'b1;
                    u_cnt   = FRAME - 1;
                    u_ph    = 2;
                end else begin
                    u_cnt--;
                end
                default: if (u_cnt == 0) begin
                    busy_Tx = 1'b0;
                    u_ph    = 0;
                end else begin
                    u_cnt--;
                end
            endcase
        end
    endtask

    task automatic prod_step();
        if (gnt != '0) begin
            gcount++;
            last_gnt = gnt;
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i]) begin
                    gq.push_back(i);
                    if (!keep_req) req[i] = 1'b0;
                end
            end
        end
        if (done) dcount++;
    endtask

    // One cycle: compare on the falling edge, then drive after the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        uart_step();
        prod_step();
    endtask

    task automatic wait_gnt(input string name, input int budget);
        int g0;
        int n;
        g0 = gcount;
        n  = 0;
        while (gcount == g0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(gcount - g0), 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // ---------------- directed scenarios ----------------
    int n;
    int cnt_hi;
    int g_before;
    int d_before;
    int exp_order[5];

    initial begin
        rst      = 1'b0;
        req      = '0;
        req_data = '0;
        cfg_sel  = 3'b000;
        cfg_we   = 1'b0;
        err_clr  = 1'b0;
        err_Tx   = 1'b0;
        busy_Tx  = 1'b0;
        uart_on  = 1'b1;
        keep_req = 1'b0;
        u_ph     = 0;
        u_cnt    = 0;
        gcount   = 0;
        dcount   = 0;
        last_gnt = '0;

        tick();
        tick();
        chk("rst_sel",    32'(sel),        32'h2);
        chk("rst_baud",   32'(ena_baud),   32'h0);
        chk("rst_idle",   32'(idle),       32'h1);
        chk("rst_ena_Tx", 32'(ena_Tx),     32'h0);
        chk("rst_data",   32'(data_in_Tx), 32'h0);
        rst = 1'b1;
        tick();
        chk("baud_up", 32'(ena_baud), 32'h1);

        // Single request from producer 1.
        req_data[1] = 8'hA5;
        req[1]      = 1'b1;
        n = 0;
        while (!ena_Tx && n < 10) begin
            tick();
            n++;
        end
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_data", 32'(data_in_Tx), 32'hA5);
        wait_gnt("t1_gnt_seen", 20);
        chk("t1_gnt", 32'(last_gnt), 32'b0010);
        wait_done("t1_done", 30);
        tick();
        chk("t1_idle", 32'(idle), 32'h1);

        // All four requesting continuously from a fresh pointer.
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        keep_req = 1'b1;
        gq.delete();
        req = 4'hF;
        n = 0;
        while (gq.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        req      = '0;
        keep_req = 1'b0;
        exp_order = '{0, 1, 2, 3, 0};
        chk("t2_count", 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) chk("t2_order", 32'(gq[i]), 32'(exp_order[i]));
        end
        wait_done("t2_done", 30);
        tick();

        // Start timeout: the transmitter never reports busy.
        uart_on     = 1'b0;
        g_before    = gcount;
        req_data[0] = 8'h3C;
        req[0]      = 1'b1;
        n = 0;
        while (!ena_Tx && n < 10) begin
            tick();
            n++;
        end
        cnt_hi = 0;
        while (ena_Tx && cnt_hi < START_TO + 10) begin
            cnt_hi++;
            tick();
        end
        req[0] = 1'b0;
        chk("t3_ena_cycles", 32'(cnt_hi), 32'(START_TO));
        chk("t3_err_to", 32'(err_to), 32'h1);
        chk("t3_no_gnt", 32'(gcount - g_before), 32'd0);
        tick();
        tick();
        chk("t3_err_to_sticky", 32'(err_to), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_clr", 32'(err_to), 32'h0);
        uart_on = 1'b1;
        tick();

        // Baud select written mid-frame is deferred until the frame ends.
        req_data[2] = 8'h77;
        req[2]      = 1'b1;
        wait_gnt("t4_gnt_seen", 20);
        cfg_sel = 3'b001;
        cfg_we  = 1'b1;
        tick();
        cfg_we = 1'b0;
        n = 0;
        while (!done && n < 30) begin
            chk("t4_sel_hold", 32'(sel), 32'h2);
            tick();
            n++;
        end
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_sel_at_done", 32'(sel), 32'h2);
        tick();
        chk("t4_baud_low", 32'(ena_baud), 32'h0);
        chk("t4_sel_new", 32'(sel), 32'h1);
        tick();
        chk("t4_baud_high", 32'(ena_baud), 32'h1);
        chk("t4_sel_kept", 32'(sel), 32'h1);
        tick();

        // Frame error flag: set during a frame, set beats clear.
        req_data[3] = 8'h5A;
        req[3]      = 1'b1;
        wait_gnt("t5_gnt_seen", 20);
        tick();
        err_Tx = 1'b1;
        tick();
        err_Tx = 1'b0;
        chk("t5_err_frame", 32'(err_frame), 32'h1);
        wait_done("t5_done", 30);
        tick();
        req[3] = 1'b1;
        wait_gnt("t5_gnt2_seen", 20);
        err_Tx  = 1'b1;
        err_clr = 1'b1;
        tick();
        err_Tx  = 1'b0;
        err_clr = 1'b0;
        chk("t5_set_wins", 32'(err_frame), 32'h1);
        wait_done("t5_done2", 30);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_clr", 32'(err_frame), 32'h0);
        tick();

        // Reset asserted while the frame is in flight.
        req_data[0] = 8'hC3;
        req[0]      = 1'b1;
        wait_gnt("t6_gnt_seen", 20);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_ena_Tx", 32'(ena_Tx),   32'h0);
        chk("t6_gnt",    32'(gnt),      32'h0);
        chk("t6_sel",    32'(sel),      32'h2);
        chk("t6_baud",   32'(ena_baud), 32'h0);
        chk("t6_idle",   32'(idle),     32'h1);
        tick();
        tick();
        rst = 1'b1;
        d_before = dcount;
        for (int i = 0; i < 20; i++) tick();
        chk("t6_no_done", 32'(dcount - d_before), 32'd0);
        chk("t6_idle_after", 32'(idle), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
